// File: rtl/ps2_key_status_pkg.sv
// Shared definitions for the PS/2 letter-key front end: prefix codes, receiver
// states and the scan-code set 2 letter table with its lookup helper.
package ps2_key_status_pkg;

  localparam int KEY_W = 26;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } letter_t;

  // Index 0 is A, index 25 is Z (listed Z..A because this is a packed concatenation).
  localparam logic [KEY_W-1:0][7:0] LETTER_CODES = {
    8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D,
    8'h15, 8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43,
    8'h33, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
  };

  function automatic letter_t letter_lookup(input logic [7:0] code);
    letter_t r;
    r.hit = 1'b0;
    r.idx = 5'd0;
    for (int i = 0; i < KEY_W; i++) begin
      if (code == LETTER_CODES[i]) begin
        r.hit = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_status_if.sv
// PS/2 pins in, decoded key levels and byte/error strobes out.
interface ps2_key_status_if;
  import ps2_key_status_pkg::*;

  logic             ps2_clk;
  logic             ps2_data;
  logic [KEY_W-1:0] key_status;
  logic             scan_valid;
  logic [7:0]       scan_code;
  logic             frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key_status, scan_valid, scan_code, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_status, scan_valid, scan_code, frame_err
  );
endinterface

// File: rtl/ps2_key_status_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, frame FSM
// and mid-frame timeout. Strobes are combinational for the cycle the stop bit lands.
module ps2_key_status_rx
  import ps2_key_status_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync, r_data_sync;
  logic          r_fclk;
  logic [FW-1:0] r_filt_cnt;
  rx_state_t     r_state, w_state_next;
  logic [2:0]    r_bit_cnt, w_bit_cnt_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_parity, w_parity_next;
  logic [TW-1:0] r_to_cnt, w_to_cnt_next;
  logic          w_fall, w_bit, w_byte_valid, w_frame_err;

  // Falling edge is flagged in the same cycle the filter commits fclk to 0.
  assign w_fall = r_fclk & ~r_clk_sync[1] & (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_bit  = r_data_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_fclk      <= 1'b1;
      r_filt_cnt  <= '0;
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      if (r_clk_sync[1] == r_fclk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_fclk     <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_to_cnt  <= w_to_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_to_cnt_next  = (r_state == ST_IDLE) ? '0 : r_to_cnt + 1'b1;
    w_byte_valid   = 1'b0;
    w_frame_err    = 1'b0;
    if (w_fall) begin
      w_to_cnt_next = '0;
      case (r_state)
        ST_IDLE: begin
          if (!w_bit) begin
            w_state_next   = ST_DATA;
            w_bit_cnt_next = '0;
          end
        end
        ST_DATA: begin
          w_shift_next = {w_bit, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
          else                   w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          w_parity_next = w_bit;
          w_state_next  = ST_STOP;
        end
        ST_STOP: begin
          if (w_bit && (^{r_shift, r_parity})) w_byte_valid = 1'b1;
          else                                 w_frame_err  = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else if ((r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES))) begin
      w_state_next  = ST_IDLE;
      w_to_cnt_next = '0;
      w_frame_err   = 1'b1;
    end
  end

  assign o_byte_valid = w_byte_valid;
  assign o_byte_data  = r_shift;
  assign o_frame_err  = w_frame_err;

endmodule

// File: rtl/ps2_key_status.sv
// PS/2 keyboard front end: turns scan-code set 2 make/break traffic into a
// held-level vector for letters A..Z (bit 0 = A).
module ps2_key_status
  import ps2_key_status_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset_n,
  ps2_key_status_if.slave    bus
);
  logic             w_byte_valid, w_frame_err;
  logic [7:0]       w_byte_data;
  letter_t          w_letter;
  logic [KEY_W-1:0] r_key_status;
  logic             r_scan_valid, r_frame_err, r_ext, r_brk;
  logic [7:0]       r_scan_code;

  ps2_key_status_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_frame_err  (w_frame_err)
  );

  assign w_letter = letter_lookup(w_byte_data);

  // Prefix flags survive frame errors; only a non-prefix byte consumes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_status <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_scan_code  <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
    end else begin
      r_scan_valid <= w_byte_valid;
      r_frame_err  <= w_frame_err;
      if (w_byte_valid) begin
        r_scan_code <= w_byte_data;
        if (w_byte_data == SC_E0) begin
          r_ext <= 1'b1;
        end else if (w_byte_data == SC_F0) begin
          r_brk <= 1'b1;
        end else begin
          if (!r_ext && w_letter.hit) r_key_status[w_letter.idx] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign bus.key_status = r_key_status;
  assign bus.scan_valid = r_scan_valid;
  assign bus.scan_code  = r_scan_code;
  assign bus.frame_err  = r_frame_err;

endmodule
